req_ack_initiator: RTL and testbench

- Synthesizable upstream initiator for the req/ack/done handshake checked by the team's procedural `expect` property tests.
- On a rising edge of `start` it issues a single-cycle `req` pulse, then waits 1..MAX_WAIT cycles for `ack`.
- On `ack` it captures `data_in` and pulses `done` one cycle later. On timeout it retries up to MAX_RETRIES times, then pulses `err`.
- Its outputs drive the DUT-side `req`/`done` signals that the `expect` sequences (`req ##[1:5] ack`, `req ##1 ack ##1 done`) observe.

---
 rtl/req_ack_if.sv | 28 ++
 rtl/req_ack_initiator.sv | 105 ++++++++++
 tb/tb_req_ack_initiator.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/req_ack_if.sv
// Handshake bundle between the req/ack initiator and its environment.
// The master side is the initiator; the slave side drives start/ack/data_in.
interface req_ack_if #(
    parameter int DATA_W      = 8,
    parameter int MAX_RETRIES = 2
);
    localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    logic              start;
    logic              ack;
    logic [DATA_W-1:0] data_in;
    logic              req;
    logic              done;
    logic              err;
    logic              busy;
    logic [DATA_W-1:0] data_out;
    logic [RC_W-1:0]   retry_cnt;

    modport master (
        input  start, ack, data_in,
        output req, done, err, busy, data_out, retry_cnt
    );

    modport slave (
        output start, ack, data_in,
        input  req, done, err, busy, data_out, retry_cnt
    );
endinterface

// File: rtl/req_ack_initiator.sv
// Upstream initiator: one req pulse per start rise, waits 1..MAX_WAIT cycles
// for ack, retries on timeout, and finishes with a done or err pulse.
module req_ack_initiator #(
    parameter int DATA_W      = 8,
    parameter int MAX_WAIT    = 5,
    parameter int MAX_RETRIES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    req_ack_if.master  bus
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam int RC_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(MAX_WAIT);
    localparam logic [RC_W-1:0]  RETRY_LAST = RC_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [RC_W-1:0]    retry_cnt_reg, retry_cnt_next;
    logic [DATA_W-1:0]  data_reg, data_next;
    logic               start_q_reg;
    logic               req_reg, done_reg, err_reg, busy_reg;
    logic               rise;

    assign rise = bus.start & ~start_q_reg;

    // Pulse outputs are flopped from the next state so they line up with the
    // state they belong to without any combinational decode on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            wait_cnt_reg  <= '0;
            retry_cnt_reg <= '0;
            data_reg      <= '0;
            start_q_reg   <= 1'b1;
            req_reg       <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            retry_cnt_reg <= retry_cnt_next;
            data_reg      <= data_next;
            start_q_reg   <= bus.start;
            req_reg       <= (state_next == S_REQ);
            done_reg      <= (state_next == S_DONE);
            err_reg       <= (state_next == S_ERR);
            busy_reg      <= (state_next != S_IDLE);
        end
    end

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        retry_cnt_next = retry_cnt_reg;
        data_next      = data_reg;
        case (state_reg)
            S_IDLE: begin
                if (rise) begin
                    retry_cnt_next = '0;
                    state_next     = S_REQ;
                end
            end
            S_REQ: begin
                wait_cnt_next = CNT_W'(1);
                state_next    = S_WAIT;
            end
            S_WAIT: begin
                // ack wins over a timeout landing in the same cycle
                if (bus.ack) begin
                    data_next  = bus.data_in;
                    state_next = S_DONE;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    if (retry_cnt_reg < RETRY_LAST) begin
                        retry_cnt_next = retry_cnt_reg + RC_W'(1);
                        state_next     = S_REQ;
                    end else begin
                        state_next = S_ERR;
                    end
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.req       = req_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;
    assign bus.busy      = busy_reg;
    assign bus.data_out  = data_reg;
    assign bus.retry_cnt = retry_cnt_reg;
endmodule

// File: tb/tb_req_ack_initiator.sv
// Randomized scoreboard bench for req_ack_initiator: a transaction-level model
// predicts req/done/err events, a negedge monitor pops and compares them.
module tb_req_ack_initiator;
    localparam int DATA_W      = 8;
    localparam int MAX_WAIT    = 5;
    localparam int MAX_RETRIES = 2;
    localparam int MAP_N       = 8192;

    localparam int EV_REQ  = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] data;
        int         rt;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    req_ack_if #(.DATA_W(DATA_W), .MAX_RETRIES(MAX_RETRIES)) bus ();

    req_ack_initiator #(
        .DATA_W(DATA_W),
        .MAX_WAIT(MAX_WAIT),
        .MAX_RETRIES(MAX_RETRIES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t        exp_q[$];
    logic [7:0] exp_data = 8'h00;
    bit         ack_map[MAP_N];
    bit         start_map[MAP_N];
    logic [7:0] data_map[MAP_N];
    int         chk_cnt = 0;
    int         pass_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    // Monitor: every output pulse must match the head of the expected queue.
    always @(negedge clk) begin
        ev_t e;
        int  kind;
        if (rst_n && (bus.req || bus.done || bus.err)) begin
            chk("onehot", int'(bus.req) + int'(bus.done) + int'(bus.err), 1);
            kind = bus.req ? EV_REQ : (bus.done ? EV_DONE : EV_ERR);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", kind + 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("kind", kind, e.kind);
                chk("cycle", cyc, e.cyc);
                if (e.kind != EV_REQ) begin
                    chk("data_out", int'(bus.data_out), int'(e.data));
                    chk("retry_cnt", int'(bus.retry_cnt), e.rt);
                end
                $display("txn ev kind=%0d cyc=%0d data_out=%02h retry=%0d", kind, cyc,
                         bus.data_out, bus.retry_cnt);
            end
        end
    end

    // Reference model: walk the attempts of one transaction starting at req cycle r0.
    task automatic model_txn(input int r0, output int end_c);
        int r;
        int rt;
        int k_hit;
        bit fin;
        r = r0;
        rt = 0;
        fin = 0;
        end_c = r0;
        while (!fin) begin
            exp_q.push_back('{EV_REQ, r, 8'h00, 0});
            k_hit = 0;
            for (int k = 1; k <= MAX_WAIT; k++)
                if (k_hit == 0 && ack_map[r + k]) k_hit = k;
            if (k_hit != 0) begin
                exp_data = data_map[r + k_hit];
                end_c = r + k_hit + 1;
                exp_q.push_back('{EV_DONE, end_c, exp_data, rt});
                fin = 1;
            end else if (rt < MAX_RETRIES) begin
                rt++;
                r = r + MAX_WAIT + 1;
            end else begin
                end_c = r + MAX_WAIT + 1;
                exp_q.push_back('{EV_ERR, end_c, exp_data, rt});
                fin = 1;
            end
        end
    endtask

    task automatic apply();
        bus.start   = start_map[cyc];
        bus.ack     = ack_map[cyc];
        bus.data_in = data_map[cyc];
    endtask

    // One transaction: start rises now, so req is expected in the next cycle.
    task automatic do_txn(input int p_ack, input int off1, input int off2,
                          input logic [7:0] dat, input bit noise);
        int r;
        int end_c;
        int last;
        r = cyc + 1;
        last = r + (MAX_RETRIES + 1) * (MAX_WAIT + 1) + 4;
        for (int c = cyc; c <= last; c++) begin
            data_map[c]  = 8'($urandom);
            ack_map[c]   = ($urandom_range(99) < p_ack);
            start_map[c] = 1'b0;
        end
        if (off1 >= 0) begin ack_map[r + off1] = 1'b1; data_map[r + off1] = dat; end
        if (off2 >= 0) begin ack_map[r + off2] = 1'b1; data_map[r + off2] = dat; end
        model_txn(r, end_c);
        start_map[cyc] = 1'b1;
        if (noise)
            for (int c = r; c <= end_c; c++) start_map[c] = 1'($urandom_range(1));
        apply();
        while (cyc < end_c + 2) begin
            @(negedge clk);
            apply();
            if (cyc == end_c) chk("busy_last", int'(bus.busy), 1);
            if (cyc == end_c + 1) chk("busy_idle", int'(bus.busy), 0);
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int r;
        bus.start = 1'b1;
        bus.ack = 1'b0;
        bus.data_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_req", int'(bus.req), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_data_out", int'(bus.data_out), 0);
        chk("rst_retry_cnt", int'(bus.retry_cnt), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("start_held_no_busy", int'(bus.busy), 0);
        bus.start = 1'b0;
        for (int c = 0; c < MAP_N; c++) begin
            start_map[c] = 1'b0; ack_map[c] = 1'b0; data_map[c] = 8'h00;
        end
        repeat (2) @(negedge clk);

        do_txn(0, 1, -1, 8'hA5, 0);
        do_txn(0, 5, -1, 8'h3C, 0);
        do_txn(0, -1, -1, 8'h00, 0);
        do_txn(0, 0, 7, 8'h5A, 0);
        do_txn(0, 4, -1, 8'hC3, 1);

        // Reset in the middle of a wait window.
        r = cyc + 1;
        exp_q.push_back('{EV_REQ, r, 8'h00, 0});
        bus.start = 1'b1;
        bus.ack = 1'b0;
        while (cyc < r + 3) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req_seen", exp_q.size(), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_data_out", int'(bus.data_out), 0);
        chk("mid_rst_retry_cnt", int'(bus.retry_cnt), 0);
        chk("mid_rst_pulses", int'(bus.req) + int'(bus.done) + int'(bus.err), 0);
        exp_q.delete();
        exp_data = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_txn(0, 2, -1, 8'h77, 0);
        do_txn(0, 8, -1, 8'h19, 0);

        for (int t = 0; t < 60; t++) begin
            int p;
            case ($urandom_range(3))
                0: p = 0;
                1: p = 5;
                2: p = 15;
                default: p = 40;
            endcase
            do_txn(p, -1, -1, 8'h00, 1'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
